// File: rtl/fpu_mul_arbiter_if.sv
// fpu_mul_arbiter_if: request and response handshake bundle between FPU issue logic and the multiplier arbiter.
interface fpu_mul_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_result;
    logic               rsp_overflow;
    logic               rsp_underflow;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_underflow
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_underflow
    );
endinterface

// File: rtl/fpu_mul_arbiter.sv
// fpu_mul_arbiter: round-robin sequencer sharing one combinational FP32 multiplier among NREQ requesters.
module fpu_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    fpu_mul_arbiter_if.slave bus,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic [31:0]      mul_result,
    input  logic             mul_overflow,
    input  logic             mul_underflow,
    output logic             busy,
    output logic [CNTW-1:0]  ovf_count,
    output logic [CNTW-1:0]  unf_count
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [31:0]     r_res;
    logic            r_ovf;
    logic            r_unf;
    logic            r_busy;
    logic            r_rsp_valid;
    logic [CNTW-1:0] r_ovf_cnt;
    logic [CNTW-1:0] r_unf_cnt;
    logic            w_any;
    logic [IDW-1:0]  w_gnt;

    // Scan downward so the last hit is the closest requester at or after the pointer.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_any = 1'b1;
                w_gnt = IDW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign bus.req_ready     = (r_state == IDLE && rst_n && w_any) ? NREQ'(1) << w_gnt : '0;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_id        = r_id;
    assign bus.rsp_result    = r_res;
    assign bus.rsp_overflow  = r_ovf;
    assign bus.rsp_underflow = r_unf;
    assign mul_a             = r_a;
    assign mul_b             = r_b;
    assign busy              = r_busy;
    assign ovf_count         = r_ovf_cnt;
    assign unf_count         = r_unf_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_ovf_cnt   <= '0;
            r_unf_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_a     <= bus.req_a[32*w_gnt +: 32];
                    r_b     <= bus.req_b[32*w_gnt +: 32];
                    r_id    <= w_gnt;
                    r_ptr   <= (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;
                    r_busy  <= 1'b1;
                    r_state <= EXEC;
                end
                EXEC: begin
                    r_res       <= mul_result;
                    r_ovf       <= mul_overflow;
                    r_unf       <= mul_underflow;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    r_ovf_cnt   <= r_ovf_cnt + CNTW'(r_ovf && !(&r_ovf_cnt));
                    r_unf_cnt   <= r_unf_cnt + CNTW'(r_unf && !(&r_unf_cnt));
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
